// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared state codes, port indices and latency limits for the memory arbiter
package data_memory_arbiter_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int MAX_LATENCY = 4;
    localparam int CNT_WIDTH = $clog2(MAX_LATENCY);
endpackage

// File: rtl/data_memory_arbiter_round_robin_picker.sv
// round_robin_picker: two-way one-hot grant; a lone requester always wins, ties go to the pointer port
module round_robin_picker
    import data_memory_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       pointer,
    output logic [1:0] grant
);
    // Grant the only requester, or the pointed-to one when both ask
    always_comb begin
        grant[0] = valid0 && (!valid1 || pointer == PORT0);
        grant[1] = valid1 && (!valid0 || pointer == PORT1);
    end
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one data_memory between two requesters, one transaction at a time
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic                  req0_write,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  req0_done,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  signal_memread,
    output logic                  signal_memwrite,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_to_write,
    input  logic [DATA_WIDTH-1:0] data_out
);
    logic [1:0]            state;
    logic                  pointer;
    logic                  winner;
    logic                  op_write;
    logic [CNT_WIDTH-1:0]  count;
    logic [1:0]            grant;
    logic                  accept;
    logic                  finish;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_wdata;

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must lie within 1..%0d", MAX_LATENCY);
    end

    round_robin_picker u_picker (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .pointer(pointer),
        .grant  (grant)
    );

    // Accept only from IDLE; finish marks the edge that closes the last strobe cycle
    always_comb begin
        accept      = state == IDLE && |grant && !reset;
        finish      = (state == ISSUE && (op_write || READ_LATENCY == 1)) || (state == WAIT && count == CNT_WIDTH'(1));
        sel_write   = grant[1] ? req1_write : req0_write;
        sel_address = grant[1] ? req1_address : req0_address;
        sel_wdata   = grant[1] ? req1_wdata : req0_wdata;
    end

    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    // Transaction sequencer: strobes are raised at acceptance so they appear in the following cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pointer         <= PORT0;
            winner          <= PORT0;
            op_write        <= 1'b0;
            count           <= '0;
            signal_memread  <= 1'b0;
            signal_memwrite <= 1'b0;
            address         <= '0;
            data_to_write   <= '0;
            req0_done       <= 1'b0;
            req1_done       <= 1'b0;
            req0_rdata      <= '0;
            req1_rdata      <= '0;
        end else begin
            req0_done <= finish && winner == PORT0;
            req1_done <= finish && winner == PORT1;
            if (accept) begin
                state           <= ISSUE;
                winner          <= grant[1];
                pointer         <= ~grant[1];
                op_write        <= sel_write;
                address         <= sel_address;
                data_to_write   <= sel_wdata;
                signal_memwrite <= sel_write;
                signal_memread  <= !sel_write;
            end else if (finish) begin
                state           <= DONE;
                signal_memread  <= 1'b0;
                signal_memwrite <= 1'b0;
                if (!op_write && winner == PORT0) req0_rdata <= data_out;
                if (!op_write && winner == PORT1) req1_rdata <= data_out;
            end else if (state == ISSUE) begin
                state <= WAIT;
                count <= CNT_WIDTH'(READ_LATENCY - 1);
            end else if (state == WAIT) begin
                count <= count - 1'b1;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule
